// File: rtl/ram_arbiter_if.sv
// Core-side and RAM-side signals of the two-port RAM arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface ram_arbiter_if;
   logic        p0_req_i;
   logic [31:0] p0_addr_i;
   logic        p0_gnt_o;
   logic [31:0] p0_rdata_o;

   logic        p1_req_i;
   logic [31:0] p1_addr_i;
   logic        p1_we_i;
   logic [31:0] p1_wdata_i;
   logic [1:0]  p1_hb_i;
   logic        p1_uload_i;
   logic        p1_gnt_o;
   logic [31:0] p1_rdata_o;

   logic        ram_ce_o;
   logic        ram_req_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic        ram_we_o;
   logic [1:0]  ram_hb_o;
   logic        ram_uload_o;
   logic        ram_gnt_i;
   logic [31:0] ram_rdata_i;

   modport slave (
      input  p0_req_i, p0_addr_i,
      input  p1_req_i, p1_addr_i, p1_we_i, p1_wdata_i, p1_hb_i, p1_uload_i,
      input  ram_gnt_i, ram_rdata_i,
      output p0_gnt_o, p0_rdata_o, p1_gnt_o, p1_rdata_o,
      output ram_ce_o, ram_req_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_hb_o, ram_uload_o
   );

   modport master (
      output p0_req_i, p0_addr_i,
      output p1_req_i, p1_addr_i, p1_we_i, p1_wdata_i, p1_hb_i, p1_uload_i,
      output ram_gnt_i, ram_rdata_i,
      input  p0_gnt_o, p0_rdata_o, p1_gnt_o, p1_rdata_o,
      input  ram_ce_o, ram_req_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_hb_o, ram_uload_o
   );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one RAM between fetch (port 0) and load/store (port 1); round-robin, or fixed port-1 priority with ARB_FIXED_PRIO_EN.
// Latency 2 cycles req-to-gnt from idle, one access per 3 cycles; requesters hold req until their one-cycle gnt.
module ram_arbiter (
   input  logic          clk_i,
   input  logic          rst_i,
   ram_arbiter_if.slave  bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ACC1    = 2'd1;
   localparam logic [1:0] S_ACC2    = 2'd2;
   localparam logic [1:0] S_RECOVER = 2'd3;

   logic [1:0] r_state;
   logic       r_owner;
   logic       r_last;

   logic       w_any_req;
   logic       w_winner;
   logic       w_access;
   logic       w_gnt;

   assign w_any_req = bus.p0_req_i | bus.p1_req_i;

`ifdef ARB_FIXED_PRIO_EN
   assign w_winner = bus.p1_req_i;
`else
   // Port 1 wins when alone, or when both request and port 0 was served last.
   assign w_winner = bus.p1_req_i & (~bus.p0_req_i | ~r_last);
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE, S_RECOVER: begin
               // The RAM grant seen in RECOVER is stale and deliberately ignored.
               if (w_any_req) begin
                  r_owner <= w_winner;
                  r_state <= S_ACC1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_ACC1: r_state <= S_ACC2;
            S_ACC2: begin
               if (bus.ram_gnt_i) begin
                  r_last  <= r_owner;
                  r_state <= S_RECOVER;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_access = (r_state == S_ACC1) || (r_state == S_ACC2);
   assign w_gnt    = (r_state == S_ACC2) && bus.ram_gnt_i;

   assign bus.ram_req_o   = w_access;
   assign bus.ram_ce_o    = w_access;
   assign bus.ram_addr_o  = !w_access ? 32'h0 : (r_owner ? bus.p1_addr_i : bus.p0_addr_i);
   assign bus.ram_wdata_o = (w_access && r_owner) ? bus.p1_wdata_i : 32'h0;
   assign bus.ram_we_o    = w_access && r_owner && bus.p1_we_i;
   assign bus.ram_hb_o    = !w_access ? 2'b00 : (r_owner ? bus.p1_hb_i : 2'b10);
   assign bus.ram_uload_o = w_access && r_owner && bus.p1_uload_i;

   assign bus.p0_gnt_o   = w_gnt && !r_owner;
   assign bus.p1_gnt_o   = w_gnt && r_owner;
   assign bus.p0_rdata_o = bus.p0_gnt_o ? bus.ram_rdata_i : 32'h0;
   assign bus.p1_rdata_o = bus.p1_gnt_o ? bus.ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model with registered grant, transaction-level reference model, directed and random traffic.
module tb_ram_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_arbiter_if bus();
   ram_arbiter dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   logic [7:0] mem     [0:255];
   logic [7:0] exp_mem [0:255];
   logic       ram_gnt;
   wire  [7:0] ra = bus.ram_addr_o[7:0];

   function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] hb, input logic u);
      case (hb)
         2'b00:   return u ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
         2'b01:   return u ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   // RAM: grant registered one cycle after req, read data combinational.
   always @(posedge clk or posedge rst)
      if (rst) ram_gnt <= 1'b0;
      else     ram_gnt <= bus.ram_req_o;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= exp_mem[i];
      end else if (bus.ram_req_o && bus.ram_we_o) begin
         mem[ra] <= bus.ram_wdata_o[7:0];
         if (bus.ram_hb_o != 2'b00) mem[ra + 8'd1] <= bus.ram_wdata_o[15:8];
         if (bus.ram_hb_o == 2'b10) begin
            mem[ra + 8'd2] <= bus.ram_wdata_o[23:16];
            mem[ra + 8'd3] <= bus.ram_wdata_o[31:24];
         end
      end
   end

   assign bus.ram_gnt_i   = ram_gnt;
   assign bus.ram_rdata_i = ext({mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]},
                                bus.ram_hb_o, bus.ram_uload_o);

   int total = 0;
   int bad   = 0;
   int mode  = 0;   // 0: drop req after gnt, 1: hold req forever, 2: random traffic
   int cyc, arb_ok, gcyc;
   bit gv, gport, m_last;
   logic [31:0] t_addr, t_wdata;
   logic        t_we, t_u;
   logic [1:0]  t_hb;
   int          g_cyc [$];
   bit          g_port[$];
   logic [31:0] g_dat [$];
   bit          rq_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [7:0] b = a[7:0];
      return {exp_mem[b + 8'd3], exp_mem[b + 8'd2], exp_mem[b + 8'd1], exp_mem[b]};
   endfunction

   task automatic set_p1(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [1:0] hb, input logic u);
      bus.p1_req_i   = 1'b1;
      bus.p1_addr_i  = a;
      bus.p1_we_i    = we;
      bus.p1_wdata_i = wd;
      bus.p1_hb_i    = hb;
      bus.p1_uload_i = u;
   endtask

   task automatic rand_p1();
      logic [1:0]  hb = 2'($urandom_range(0, 2));
      logic [31:0] a  = $urandom;
      logic [31:0] wd = $urandom;
      if (hb == 2'b10) a = a & ~32'h3;
      if (hb == 2'b01) a = a & ~32'h1;
      if (hb == 2'b00) wd = wd & 32'hFF;
      if (hb == 2'b01) wd = wd & 32'hFFFF;
      set_p1(a, 1'($urandom_range(0, 1)), wd, hb, 1'($urandom_range(0, 1)));
   endtask

   task automatic clear_log();
      g_cyc.delete(); g_port.delete(); g_dat.delete(); rq_log.delete();
   endtask

   task automatic do_reset(input bit keep);
      @(negedge clk);
      rst  = 1'b1;
      mode = 0;
      if (!keep) begin
         bus.p0_req_i = 1'b0; bus.p0_addr_i = 32'h0;
         set_p1(32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
         bus.p1_req_i = 1'b0;
      end
      repeat (2) @(negedge clk);
      chk("rst_gnt0",  bus.p0_gnt_o,    0);
      chk("rst_gnt1",  bus.p1_gnt_o,    0);
      chk("rst_req",   bus.ram_req_o,   0);
      chk("rst_ce",    bus.ram_ce_o,    0);
      chk("rst_addr",  bus.ram_addr_o,  0);
      chk("rst_wdata", bus.ram_wdata_o, 0);
      chk("rst_we",    bus.ram_we_o,    0);
      chk("rst_hb",    bus.ram_hb_o,    0);
      chk("rst_uload", bus.ram_uload_o, 0);
      chk("rst_rd0",   bus.p0_rdata_o,  0);
      chk("rst_rd1",   bus.p1_rdata_o,  0);
      rst = 1'b0;
      cyc = 0; arb_ok = 0; gv = 0; gcyc = 0; m_last = 1'b1;
      clear_log();
   endtask

   // One cycle: check outputs of cycle cyc, model the edge ending it, then advance requesters.
   task automatic step();
      bit eg0, eg1, er, w;
      logic [31:0] ed;
      er  = gv && (cyc == gcyc - 1 || cyc == gcyc);
      eg0 = gv && cyc == gcyc && !gport;
      eg1 = gv && cyc == gcyc && gport;
      ed  = ext(exp_word(t_addr), t_hb, t_u);
      rq_log.push_back(bus.ram_req_o);
      chk("gnt0",     bus.p0_gnt_o,    eg0);
      chk("gnt1",     bus.p1_gnt_o,    eg1);
      chk("ram_req",  bus.ram_req_o,   er);
      chk("ram_ce",   bus.ram_ce_o,    er);
      chk("ram_addr", bus.ram_addr_o,  er ? t_addr  : 32'h0);
      chk("ram_we",   bus.ram_we_o,    er ? t_we    : 1'b0);
      chk("ram_wd",   bus.ram_wdata_o, er ? t_wdata : 32'h0);
      chk("ram_hb",   bus.ram_hb_o,    er ? t_hb    : 2'b00);
      chk("ram_ul",   bus.ram_uload_o, er ? t_u     : 1'b0);
      chk("rdata0",   bus.p0_rdata_o,  eg0 ? ed : 32'h0);
      if (!(eg1 && t_we)) chk("rdata1", bus.p1_rdata_o, eg1 ? ed : 32'h0);
      if (eg0 || eg1) begin
         g_cyc.push_back(cyc); g_port.push_back(eg1);
         g_dat.push_back(eg1 ? bus.p1_rdata_o : bus.p0_rdata_o);
         if (eg1 && t_we) begin
            exp_mem[t_addr[7:0]] = t_wdata[7:0];
            if (t_hb != 2'b00) exp_mem[t_addr[7:0] + 8'd1] = t_wdata[15:8];
            if (t_hb == 2'b10) begin
               exp_mem[t_addr[7:0] + 8'd2] = t_wdata[23:16];
               exp_mem[t_addr[7:0] + 8'd3] = t_wdata[31:24];
            end
         end
      end
      if (cyc >= arb_ok && (bus.p0_req_i || bus.p1_req_i)) begin
`ifdef ARB_FIXED_PRIO_EN
         w = bus.p1_req_i;
`else
         w = (bus.p0_req_i && bus.p1_req_i) ? !m_last : bus.p1_req_i;
`endif
         gv = 1; gport = w; gcyc = cyc + 2; arb_ok = cyc + 3; m_last = w;
         if (w) begin
            t_addr = bus.p1_addr_i; t_we = bus.p1_we_i; t_wdata = bus.p1_wdata_i;
            t_hb = bus.p1_hb_i; t_u = bus.p1_uload_i;
         end else begin
            t_addr = bus.p0_addr_i; t_we = 1'b0; t_wdata = 32'h0; t_hb = 2'b10; t_u = 1'b0;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (mode == 2) begin
         if (eg0 || !bus.p0_req_i) begin
            bus.p0_req_i  = 1'($urandom_range(0, 1));
            bus.p0_addr_i = $urandom & ~32'h3;
         end
         if (eg1 || !bus.p1_req_i) begin
            if ($urandom_range(0, 1) == 1) rand_p1();
            else bus.p1_req_i = 1'b0;
         end
      end else if (mode == 0) begin
         if (eg0) bus.p0_req_i = 1'b0;
         if (eg1) bus.p1_req_i = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      bus.p0_req_i = 1'b0; bus.p0_addr_i = 32'h0;
      set_p1(32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
      bus.p1_req_i = 1'b0;
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'($urandom);
      exp_mem[0] = 8'hEF; exp_mem[1] = 8'hBE; exp_mem[2] = 8'hAD; exp_mem[3] = 8'hDE;

      // Single fetch from idle
      do_reset(0);
      bus.p0_req_i = 1'b1; bus.p0_addr_i = 32'h0;
      repeat (5) step();
      chk("fetch_n", g_cyc.size(), 1);
      if (g_cyc.size() >= 1) begin
         chk("fetch_cyc",  g_cyc[0],  2);
         chk("fetch_port", g_port[0], 0);
         chk("fetch_dat",  g_dat[0],  32'hDEADBEEF);
      end
      chk("fetch_req1", rq_log[1], 1);
      chk("fetch_req2", rq_log[2], 1);
      chk("fetch_req3", rq_log[3], 0);

      // Byte store then signed and unsigned byte loads
      do_reset(0);
      set_p1(32'h5, 1'b1, 32'h80, 2'b00, 1'b0);
      repeat (4) step();
      set_p1(32'h5, 1'b0, 32'h0, 2'b00, 1'b0);
      repeat (4) step();
      set_p1(32'h5, 1'b0, 32'h0, 2'b00, 1'b1);
      repeat (4) step();
      chk("ldst_n", g_cyc.size(), 3);
      if (g_cyc.size() >= 3) begin
         chk("ld_signed",   g_dat[1], 32'hFFFFFF80);
         chk("ld_unsigned", g_dat[2], 32'h00000080);
      end

      // Both ports requesting continuously from reset
      do_reset(0);
      mode = 1;
      bus.p0_req_i = 1'b1; bus.p0_addr_i = 32'h10;
      set_p1(32'h22, 1'b0, 32'h0, 2'b01, 1'b1);
      repeat (13) step();
      chk("cont_n", (g_cyc.size() >= 4), 1);
      if (g_cyc.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("cont_cyc", g_cyc[i], 2 + 3 * i);
`ifdef ARB_FIXED_PRIO_EN
            chk("cont_port", g_port[i], 1);
`else
            chk("cont_port", g_port[i], i % 2);
`endif
         end
      end

      // Stale grant in RECOVER must not produce a grant; arbiter returns to idle
      do_reset(0);
      set_p1(32'h40, 1'b0, 32'h0, 2'b10, 1'b0);
      repeat (6) step();
      chk("stale_n", g_cyc.size(), 1);
      bus.p0_req_i = 1'b1; bus.p0_addr_i = 32'h44;
      repeat (4) step();
      chk("stale_n2", g_cyc.size(), 2);
      if (g_cyc.size() >= 2) chk("stale_cyc", g_cyc[1], 8);

      // Reset asserted during ACC1 abandons the access
      do_reset(0);
      bus.p0_req_i = 1'b1; bus.p0_addr_i = 32'h8;
      set_p1(32'h30, 1'b1, 32'h1234, 2'b01, 1'b0);
      step();
      chk("mid_req_before", bus.ram_req_o, 1);
      rst = 1'b1;
      #1;
      chk("mid_gnt0", bus.p0_gnt_o,  0);
      chk("mid_gnt1", bus.p1_gnt_o,  0);
      chk("mid_req",  bus.ram_req_o, 0);
      do_reset(1);
      repeat (8) step();
      chk("mid_n", g_cyc.size(), 2);
      if (g_cyc.size() >= 1) begin
         chk("mid_cyc",  g_cyc[0],  2);
`ifdef ARB_FIXED_PRIO_EN
         chk("mid_port", g_port[0], 1);
`else
         chk("mid_port", g_port[0], 0);
`endif
      end

      // Random traffic against the reference model
      do_reset(0);
      mode = 2;
      repeat (600) step();
      chk("rand_active", (g_cyc.size() > 100), 1);
      mode = 0;
      bus.p0_req_i = 1'b0;
      bus.p1_req_i = 1'b0;
      repeat (5) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
